// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM state encoding
// and the helper that sizes per-bit counters.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake, operand and result bundle of the serial subtractor.
// The master drives the request; the slave (the subtractor) returns the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero, overflow
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, built from two half-subtractor
// stages whose borrows are ORed together.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic w_d1;
  logic w_b1;
  logic w_b2;

  assign w_d1 = a ^ b;
  assign w_b1 = ~a & b;
  assign d    = w_d1 ^ bin;
  assign w_b2 = ~w_d1 & bin;
  assign bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full
// subtractor cell; results and flags update only on entry to DONE.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic             r_amsb;
  logic             r_bmsb;
  logic             r_borrow;
  logic             r_zero;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_fs (
    .a   (r_sa[0]),
    .b   (r_sb[0]),
    .bin (r_bin),
    .d   (w_d),
    .bout(w_bout)
  );

  // The result register fills from the MSB so the last bit lands it aligned.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_amsb   <= 1'b0;
      r_bmsb   <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_amsb  <= bus.a[WIDTH-1];
            r_bmsb  <= bus.b[WIDTH-1];
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_next;
          r_bin <= w_bout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff   <= w_res_next;
            r_borrow <= w_bout;
            r_zero   <= (w_res_next == '0);
            r_ovf    <= (r_amsb != r_bmsb) && (w_res_next[WIDTH-1] != r_amsb);
            r_state  <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == RUN);
  assign bus.done     = (r_state == DONE);
  assign bus.diff     = r_diff;
  assign bus.borrow   = r_borrow;
  assign bus.zero     = r_zero;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=32:
// directed vector table, handshake corner cases, mid-run reset and random sweep.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(32)) bus32 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8.slave)
  );

  serial_subtractor #(.WIDTH(32)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus32.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input bit wide, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (wide) begin
      bus32.start = 1'b1; bus32.a = a; bus32.b = b;
    end else begin
      bus8.start = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0];
    end
    @(negedge clk);
    bus8.start  = 1'b0;
    bus32.start = 1'b0;
  endtask

  // Counts cycles from the request cycle until done is seen, bounded.
  task automatic waitDone(input bit wide, output int cycles, output int busyCycles);
    logic d;
    cycles = 1;
    busyCycles = 0;
    d = wide ? bus32.done : bus8.done;
    while (!d && cycles < 60) begin
      if (wide ? bus32.busy : bus8.busy) busyCycles++;
      @(negedge clk);
      cycles++;
      d = wide ? bus32.done : bus8.done;
    end
  endtask

  task automatic checkRandom(input bit wide, input logic [31:0] a, input logic [31:0] b);
    int cyc, bcyc;
    logic [31:0] expDiff, gotDiff;
    logic expBorrow, expZero, expOvf, msbA, msbB, msbD;
    applyStimulus(wide, a, b);
    waitDone(wide, cyc, bcyc);
    if (wide) begin
      expDiff = a - b;
      expBorrow = (a < b);
      msbA = a[31]; msbB = b[31]; msbD = expDiff[31];
      gotDiff = bus32.diff;
      checkOutput("rand32_done", {31'd0, bus32.done}, 32'd1);
      checkOutput("rand32_diff", gotDiff, expDiff);
      checkOutput("rand32_borrow", {31'd0, bus32.borrow}, {31'd0, expBorrow});
    end else begin
      expDiff = {24'd0, a[7:0] - b[7:0]};
      expBorrow = (a[7:0] < b[7:0]);
      msbA = a[7]; msbB = b[7]; msbD = expDiff[7];
      gotDiff = {24'd0, bus8.diff};
      checkOutput("rand8_done", {31'd0, bus8.done}, 32'd1);
      checkOutput("rand8_diff", gotDiff, expDiff);
      checkOutput("rand8_borrow", {31'd0, bus8.borrow}, {31'd0, expBorrow});
    end
    expZero = (expDiff == 32'd0);
    expOvf  = (msbA != msbB) && (msbD != msbA);
    checkOutput(wide ? "rand32_zero" : "rand8_zero",
                {31'd0, wide ? bus32.zero : bus8.zero}, {31'd0, expZero});
    checkOutput(wide ? "rand32_ovf" : "rand8_ovf",
                {31'd0, wide ? bus32.overflow : bus8.overflow}, {31'd0, expOvf});
  endtask

  initial begin
    vec_t vecs[7];
    int   cyc, bcyc;
    bit   held, sawDone;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};

    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus32.start = 1'b0; bus32.a = '0; bus32.b = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, bus8.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus8.done}, 32'd0);
    checkOutput("reset_diff", {24'd0, bus8.diff}, 32'd0);
    checkOutput("reset_flags", {29'd0, bus8.borrow, bus8.zero, bus8.overflow}, 32'd0);
    checkOutput("reset_diff32", bus32.diff, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, {24'd0, vecs[i].a}, {24'd0, vecs[i].b});
      waitDone(1'b0, cyc, bcyc);
      checkOutput($sformatf("vec%0d_latency", i), cyc, 32'd9);
      checkOutput($sformatf("vec%0d_busy_cycles", i), bcyc, 32'd8);
      checkOutput($sformatf("vec%0d_diff", i), {24'd0, bus8.diff}, {24'd0, vecs[i].diff});
      checkOutput($sformatf("vec%0d_borrow", i), {31'd0, bus8.borrow}, {31'd0, vecs[i].borrow});
      checkOutput($sformatf("vec%0d_zero", i), {31'd0, bus8.zero}, {31'd0, vecs[i].zero});
      checkOutput($sformatf("vec%0d_ovf", i), {31'd0, bus8.overflow}, {31'd0, vecs[i].ovf});
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, bus8.done}, 32'd0);
    end

    // start during RUN must be ignored
    applyStimulus(1'b0, 32'h20, 32'h01);
    repeat (2) @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00;
    @(negedge clk);
    bus8.start = 1'b0;
    waitDone(1'b0, cyc, bcyc);
    checkOutput("ignore_done", {31'd0, bus8.done}, 32'd1);
    checkOutput("ignore_diff", {24'd0, bus8.diff}, 32'h1F);

    // back-to-back accept from the DONE cycle; diff must hold meanwhile
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0;
    cyc = 1;
    held = 1'b1;
    while (!bus8.done && cyc < 60) begin
      if (bus8.diff !== 8'h1F) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_latency", cyc, 32'd9);
    checkOutput("b2b_diff_held", {31'd0, held}, 32'd1);
    checkOutput("b2b_diff", {24'd0, bus8.diff}, 32'h0F);

    // reset asserted in the 4th RUN cycle aborts the operation
    applyStimulus(1'b0, 32'h33, 32'h11);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, bus8.busy}, 32'd0);
    checkOutput("abort_done", {31'd0, bus8.done}, 32'd0);
    checkOutput("abort_diff", {24'd0, bus8.diff}, 32'd0);
    checkOutput("abort_flags", {29'd0, bus8.borrow, bus8.zero, bus8.overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", {31'd0, sawDone}, 32'd0);
    applyStimulus(1'b0, 32'h09, 32'h04);
    waitDone(1'b0, cyc, bcyc);
    checkOutput("post_reset_latency", cyc, 32'd9);
    checkOutput("post_reset_diff", {24'd0, bus8.diff}, 32'h05);

    for (int i = 0; i < 1000; i++) begin
      checkRandom(1'b0, $urandom, $urandom);
    end
    for (int i = 0; i < 1000; i++) begin
      checkRandom(1'b1, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
